moving_avg_scheduler: RTL and testbench

MOVING_AVG_SCHEDULER -- requirements
Module: moving_avg_scheduler

---
 rtl/moving_avg_scheduler.sv | 155 +++++++++++++++
 tb/tb_moving_avg_scheduler.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_scheduler.sv
// ---------------------------------------------------------------------------
// moving_avg_scheduler
//
// Purpose:
//   Shares a single external moving-average unit between two requesters.
//   A round-robin arbiter accepts one sample at a time. The sample is
//   presented on avg_data, and avg_strobe pulses for one cycle to load it.
//   The scheduler waits RESULT_LAT cycles and then captures the averager
//   output. It holds that result on res_* until the consumer takes it.
//   Only one transaction is in flight at any time.
//
// Parameters:
//   DATA_W      sample / result width in bits
//   RESULT_LAT  cycles from the strobe cycle to a valid avg_result (1..15)
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   req0_valid   requester 0 has a sample
//   req0_data    requester 0 sample
//   req0_ready   requester 0 sample accepted (combinational, IDLE only)
//   req1_valid   requester 1 has a sample
//   req1_data    requester 1 sample
//   req1_ready   requester 1 sample accepted (combinational, IDLE only)
//   avg_data     sample driven to the averager data input
//   avg_strobe   one-cycle load pulse to the averager
//   avg_result   averager output
//   res_valid    captured result available
//   res_data     captured result
//   res_chan     requester index that produced res_data
//   res_ready    consumer accepts the result
//   busy         high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module moving_avg_scheduler #(
  parameter int DATA_W     = 8,
  parameter int RESULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] avg_data,
  output logic              avg_strobe,
  input  logic [DATA_W-1:0] avg_result,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_chan,
  input  logic              res_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    HOLD
  } state_t;

  // The WAIT counter is loaded with RESULT_LAT-1 and capture happens when
  // it reaches zero. This gives exactly RESULT_LAT cycles in WAIT.
  localparam logic [3:0] LAT_LAST = 4'(RESULT_LAT - 1);

  state_t      r_state;
  logic        r_prio;
  logic [3:0]  r_waitCnt;

  logic        w_grantValid;
  logic        w_grantChan;
  logic        w_accept;

  // Round-robin choice. A lone valid requester wins. When both are valid,
  // the channel held in r_prio wins. r_prio always names the channel that
  // was not granted last, and reset makes channel 0 the favoured one.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantChan  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grantValid = 1'b1;
      w_grantChan  = r_prio;
    end else if (req0_valid) begin
      w_grantValid = 1'b1;
      w_grantChan  = 1'b0;
    end else if (req1_valid) begin
      w_grantValid = 1'b1;
      w_grantChan  = 1'b1;
    end
  end

  // Ready is only offered from IDLE. It is masked by rst so that both
  // readies read low for the whole time reset is asserted.
  assign w_accept   = (r_state == IDLE) && !rst && w_grantValid;
  assign req0_ready = w_accept && !w_grantChan;
  assign req1_ready = w_accept &&  w_grantChan;
  assign busy       = (r_state != IDLE);

  // Transaction sequencer. Every output driven from here is a register, so
  // the averager and the consumer see glitch-free strobe and result signals.
  // The priority pointer only moves when a handshake actually completes.
  // A requester that drops valid before being accepted therefore leaves
  // no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_waitCnt  <= '0;
      avg_data   <= '0;
      avg_strobe <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_chan   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            avg_data   <= w_grantChan ? req1_data : req0_data;
            res_chan   <= w_grantChan;
            r_prio     <= ~w_grantChan;
            avg_strobe <= 1'b1;
            r_state    <= STROBE;
          end
        end
        STROBE: begin
          avg_strobe <= 1'b0;
          r_waitCnt  <= LAT_LAST;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (r_waitCnt == 4'd0) begin
            res_data  <= avg_result;
            res_valid <= 1'b1;
            r_state   <= HOLD;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          avg_strobe <= 1'b0;
          res_valid  <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_moving_avg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_moving_avg_scheduler
//
// Purpose:
//   Self-checking bench for moving_avg_scheduler. Inputs are driven on the
//   falling edge, and outputs are sampled 1 time unit later.
//
//   The reference model works at transaction level. It tracks whether a
//   request is in flight and the cycle it was accepted in. Each expected
//   output is derived from the age of that transaction:
//     - strobe at age 1
//     - result capture at age RESULT_LAT+1
//     - result valid from age RESULT_LAT+2
// ---------------------------------------------------------------------------
module tb_moving_avg_scheduler;

  localparam int DATA_W     = 8;
  localparam int RESULT_LAT = 2;
  localparam int VEC_W      = 6 + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] avg_data;
  logic              avg_strobe;
  logic [DATA_W-1:0] avg_result;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_chan;
  logic              res_ready;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  // Transaction-level reference state
  int                cyc      = 0;
  bit                started  = 0;
  bit                mActive;
  int                mAccT;
  bit                mPrio;
  bit                mResChan;
  logic [DATA_W-1:0] mAvgData;
  logic [DATA_W-1:0] mResData;
  bit                eR0, eR1;
  logic [VEC_W-1:0]  expVec;
  logic [VEC_W-1:0]  gotVec;

  moving_avg_scheduler #(
    .DATA_W    (DATA_W),
    .RESULT_LAT(RESULT_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .avg_data  (avg_data),
    .avg_strobe(avg_strobe),
    .avg_result(avg_result),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_chan  (res_chan),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Packs every DUT output in the same order the model uses.
  function automatic logic [VEC_W-1:0] dutVec();
    return {busy, req0_ready, req1_ready, avg_strobe, res_valid, res_chan,
            avg_data, res_data};
  endfunction

  // Returns the model to its reset state.
  function automatic void model_reset();
    mActive  = 0;
    mAccT    = 0;
    mPrio    = 0;
    mResChan = 0;
    mAvgData = '0;
    mResData = '0;
  endfunction

  // Computes the outputs expected in the current cycle. Readies follow
  // round-robin on the current valids. The other outputs depend only on
  // the age of the in-flight transaction.
  function automatic void model_eval();
    int age;
    bit strobe;
    bit rv;
    age    = cyc - mAccT;
    strobe = mActive && (age == 1);
    rv     = mActive && (age >= RESULT_LAT + 2);
    eR0    = 0;
    eR1    = 0;
    if (!rst && !mActive) begin
      if (req0_valid && req1_valid) begin
        if (mPrio) eR1 = 1;
        else       eR0 = 1;
      end else if (req0_valid) begin
        eR0 = 1;
      end else if (req1_valid) begin
        eR1 = 1;
      end
    end
    expVec = {mActive, eR0, eR1, strobe, rv, mResChan, mAvgData, mResData};
  endfunction

  // Applies the effect of the rising edge that ends the current cycle.
  function automatic void model_commit();
    int age;
    age = cyc - mAccT;
    if (!mActive) begin
      if (eR0 || eR1) begin
        mActive  = 1;
        mAccT    = cyc;
        mResChan = eR1;
        mAvgData = eR1 ? req1_data : req0_data;
        mPrio    = !eR1;
      end
    end else begin
      if (age == RESULT_LAT + 1) mResData = avg_result;
      if (age >= RESULT_LAT + 2 && res_ready) mActive = 0;
    end
  endfunction

  // Advances one cycle. It first applies the pending edge to the model, then
  // drives new inputs on the falling edge, and returns at the sample point
  // with expVec up to date.
  task automatic drive_cycle(input logic r, input logic v0, input logic v1,
                             input logic [DATA_W-1:0] d0,
                             input logic [DATA_W-1:0] d1,
                             input logic rr, input logic [DATA_W-1:0] ar);
    if (started && !rst) model_commit();
    if (started) cyc++;
    started = 1;
    @(negedge clk);
    rst        = r;
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = d0;
    req1_data  = d1;
    res_ready  = rr;
    avg_result = ar;
    if (r) model_reset();
    #1;
    model_eval();
  endtask

  // Reset holds every output at its reset value, even with both requesters
  // valid.
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1,
                  8'($urandom));
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs cyc=%0d got=%h expected=%h", cyc,
                 gotVec, expVec);
      end
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL reset_ready cyc=%0d got=%b expected=00", cyc,
                 {req0_ready, req1_ready});
      end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, '0);
    vectors++;
    gotVec = dutVec();
    if (gotVec !== expVec) begin
      miscompares++;
      $display("[TB] FAIL reset_release cyc=%0d got=%h expected=%h", cyc,
               gotVec, expVec);
    end
  endtask

  // A single req0 sample of 0x01, with the averager returning 0x05.
  task automatic test_single();
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 8'h05);
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_ready got=%b expected=1", req0_ready);
    end
    for (int k = 1; k <= 6; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 8'h05);
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL single_seq k=%0d got=%h expected=%h", k, gotVec,
                 expVec);
      end
      if (k == 1) begin
        vectors++;
        if (avg_strobe !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL single_strobe got=%b expected=1", avg_strobe);
        end
      end
      if (k == 3) begin
        vectors++;
        if (res_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL single_early_valid got=%b expected=0",
                   res_valid);
        end
      end
      if (k == 4) begin
        vectors++;
        if ({res_valid, res_data, res_chan} !== {1'b1, 8'h05, 1'b0}) begin
          miscompares++;
          $display("[TB] FAIL single_result got=%b/%h/%b expected=1/05/0",
                   res_valid, res_data, res_chan);
        end
      end
    end
  endtask

  // Both requesters are valid all the time. Grants must alternate 0,1,0,1.
  task automatic test_contention();
    int                grants[$];
    logic [DATA_W-1:0] samples[$];
    drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, '0);
    for (int c = 0; c < 60 && samples.size() < 4; c++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 8'h02, 8'h03, 1'b1, 8'($urandom));
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL contention_seq cyc=%0d got=%h expected=%h", cyc,
                 gotVec, expVec);
      end
      if (req0_ready === 1'b1) grants.push_back(0);
      if (req1_ready === 1'b1) grants.push_back(1);
      if (avg_strobe === 1'b1) samples.push_back(avg_data);
    end
    vectors++;
    if (samples.size() != 4 || grants.size() < 4) begin
      miscompares++;
      $display("[TB] FAIL contention_count got=%0d/%0d expected=4/4",
               grants.size(), samples.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (grants[i] != (i % 2) ||
            samples[i] !== ((i % 2) ? 8'h03 : 8'h02)) begin
          miscompares++;
          $display("[TB] FAIL contention_order i=%0d got=%0d/%h expected=%0d/%h",
                   i, grants[i], samples[i], i % 2,
                   (i % 2) ? 8'h03 : 8'h02);
        end
      end
    end
  endtask

  // The consumer stalls for 5 cycles in HOLD. The result must stay frozen,
  // and new requests must not be accepted while it is held.
  task automatic test_backpressure();
    logic [DATA_W-1:0] bpRes;
    logic [DATA_W-1:0] bpData;
    bit                seen;
    bpRes  = 8'($urandom);
    bpData = 8'($urandom);
    seen   = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      drive_cycle(1'b0, 1'b0, !mActive, '0, bpData, 1'b0, bpRes);
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL bp_setup cyc=%0d got=%h expected=%h", cyc,
                 gotVec, expVec);
      end
      if (res_valid === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL bp_timeout got=no res_valid expected=res_valid");
    end
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0,
                  8'($urandom));
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL bp_hold cyc=%0d got=%h expected=%h", cyc,
                 gotVec, expVec);
      end
      vectors++;
      if ({res_valid, res_data, res_chan, req0_ready, req1_ready, avg_strobe}
          !== {1'b1, bpRes, 1'b1, 3'b000}) begin
        miscompares++;
        $display("[TB] FAIL bp_stable got=%b/%h/%b/%b%b%b expected=1/%h/1/000",
                 res_valid, res_data, res_chan, req0_ready, req1_ready,
                 avg_strobe, bpRes);
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1,
                  8'($urandom));
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL bp_release cyc=%0d got=%h expected=%h", cyc,
                 gotVec, expVec);
      end
    end
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 8'($urandom));
    end
  endtask

  // Reset is pulsed one cycle after STROBE. The aborted transaction must
  // leave no result behind, and a new request is taken straight away.
  task automatic test_reset_mid_wait();
    logic [DATA_W-1:0] nd;
    nd = 8'($urandom);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'($urandom), '0, 1'b1, 8'($urandom));
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 8'($urandom));
    vectors++;
    if (avg_strobe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rmw_strobe got=%b expected=1", avg_strobe);
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b1,
                8'($urandom));
    vectors++;
    if (dutVec() !== '0) begin
      miscompares++;
      $display("[TB] FAIL rmw_reset_values got=%h expected=0", dutVec());
    end
    drive_cycle(1'b0, 1'b0, 1'b1, '0, nd, 1'b1, 8'($urandom));
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rmw_first_accept got=%b expected=1", req1_ready);
    end
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 8'($urandom));
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL rmw_after cyc=%0d got=%h expected=%h", cyc,
                 gotVec, expVec);
      end
    end
  endtask

  // Eight back-to-back requests must give eight strobes. Each strobe must
  // carry its own sample, and the strobes must be well spaced.
  task automatic test_strobe_spacing();
    logic [DATA_W-1:0] seqData [8];
    logic [DATA_W-1:0] strobeData[$];
    int                strobeCyc[$];
    int                idx;
    bit                v;
    seqData = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03};
    idx = 0;
    for (int c = 0; c < 70; c++) begin
      v = (idx < 8);
      drive_cycle(1'b0, v, 1'b0, v ? seqData[idx] : '0, '0, 1'b1,
                  8'($urandom));
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL spacing_seq cyc=%0d got=%h expected=%h", cyc,
                 gotVec, expVec);
      end
      if (avg_strobe === 1'b1) begin
        strobeData.push_back(avg_data);
        strobeCyc.push_back(cyc);
      end
      if (v && req0_ready === 1'b1) idx++;
    end
    vectors++;
    if (strobeData.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL spacing_count got=%0d expected=8",
               strobeData.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (strobeData[i] !== seqData[i]) begin
          miscompares++;
          $display("[TB] FAIL spacing_data i=%0d got=%h expected=%h", i,
                   strobeData[i], seqData[i]);
        end
        if (i > 0) begin
          vectors++;
          if (strobeCyc[i] - strobeCyc[i-1] < RESULT_LAT + 2) begin
            miscompares++;
            $display("[TB] FAIL spacing_gap i=%0d got=%0d expected>=%0d", i,
                     strobeCyc[i] - strobeCyc[i-1], RESULT_LAT + 2);
          end
        end
      end
    end
  endtask

  // Random valids, data, consumer stalls and occasional resets, all
  // checked against the model.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive_cycle(($urandom_range(63) == 0), ($urandom_range(2) != 0),
                  ($urandom_range(2) != 0), 8'($urandom), 8'($urandom),
                  ($urandom_range(3) != 0), 8'($urandom));
      vectors++;
      gotVec = dutVec();
      if (gotVec !== expVec) begin
        miscompares++;
        $display("[TB] FAIL random cyc=%0d got=%h expected=%h", cyc, gotVec,
                 expVec);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    res_ready  = 1'b0;
    avg_result = '0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_wait();
    test_strobe_spacing();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
